// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port 16-bit data memory behind a valid/ready
// request channel and a valid/ready response channel. A request is accepted
// in IDLE, the access happens after WAIT_CYCLES+1 busy cycles, and the
// response is held in RESP until the processor takes it.
module data_mem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_rdata,
   output logic        resp_err
);

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
   localparam logic [16:0] DEPTH_W  = 17'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic        accept_s;
   logic        access_s;
   logic        release_s;
   logic        in_range_s;
   logic [AW-1:0] index_s;

   logic [3:0]  wait_cnt_r;
   logic        write_r;
   logic [15:0] addr_r;
   logic [15:0] wdata_r;

   logic        req_ready_r;
   logic        resp_valid_r;
   logic        resp_err_r;
   logic [15:0] resp_rdata_r;

   logic [15:0] mem_r [DEPTH];

   // Range check and array index are taken from the latched request only.
   always_comb begin
      in_range_s = ({1'b0, addr_r} < DEPTH_W);
      index_s    = addr_r[AW-1:0];
   end

   // Next-state logic and the single-cycle accept/access/release strobes.
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      access_s     = 1'b0;
      release_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               accept_s     = 1'b1;
               state_next_s = ST_BUSY;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (wait_cnt_r == 4'd0) begin
               access_s     = 1'b1;
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_BUSY;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               release_s    = 1'b1;
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RESP;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register; req_ready is registered from the next state so it is
   // high exactly in IDLE cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         req_ready_r <= 1'b1;
      end else begin
         state_r     <= state_next_s;
         req_ready_r <= (state_next_s == ST_IDLE);
      end
   end

   // Request latch and wait-state counter; inputs only matter on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_r <= 4'd0;
         write_r    <= 1'b0;
         addr_r     <= 16'h0000;
         wdata_r    <= 16'h0000;
      end else if (accept_s) begin
         wait_cnt_r <= WAIT_LOAD;
         write_r    <= req_write;
         addr_r     <= req_addr;
         wdata_r    <= req_wdata;
      end else if ((state_r == ST_BUSY) && (wait_cnt_r != 4'd0)) begin
         wait_cnt_r <= wait_cnt_r - 4'd1;
      end
   end

   // Response registers: loaded on the access edge, cleared on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= 16'h0000;
      end else if (access_s) begin
         resp_valid_r <= 1'b1;
         resp_err_r   <= ~in_range_s;
         resp_rdata_r <= (in_range_s && !write_r) ? mem_r[index_s] : 16'h0000;
      end else if (release_s) begin
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= 16'h0000;
      end
   end

   // Storage array: cleared by reset, written only by in-range writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 16'h0000;
         end
      end else if (access_s && write_r && in_range_s) begin
         mem_r[index_s] <= wdata_r;
      end
   end

   assign req_ready  = req_ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_err   = resp_err_r;
   assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: main instance with WAIT_CYCLES=2 plus two
// instances (0 and 15 wait states) used for the back-to-back spacing sweep.
module tb_data_mem_responder;

   localparam int DEPTH  = 256;
   localparam int W_MAIN = 2;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_ready;

   logic        req_ready,  resp_valid,  resp_err;
   logic [15:0] resp_rdata;
   logic        r0_ready,   r0_valid,    r0_err;
   logic [15:0] r0_rdata;
   logic        r15_ready,  r15_valid,   r15_err;
   logic [15:0] r15_rdata;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;

   logic [15:0] model [DEPTH];

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W_MAIN)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err));

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(r0_ready),
      .resp_valid(r0_valid), .resp_ready(resp_ready),
      .resp_rdata(r0_rdata), .resp_err(r0_err));

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(15)) dut_w15 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(r15_ready),
      .resp_valid(r15_valid), .resp_ready(resp_ready),
      .resp_rdata(r15_rdata), .resp_err(r15_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
   endtask

   // Present a request and return #1 after the edge that accepts it.
   task automatic send(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
      int n = 0;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      while (req_ready !== 1'b1 && n < 64) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 64) begin
         total_cnt++;
         $display("FAIL send_timeout: req_ready=%b required 1", req_ready);
      end
      @(posedge clk); #1;
   endtask

   // Wiggle request inputs while busy; return number of edges to resp_valid.
   task automatic wait_resp(output int lat);
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 64) begin
         req_valid = 1'($urandom_range(0, 1));
         req_write = 1'($urandom_range(0, 1));
         req_addr  = 16'($urandom);
         req_wdata = 16'($urandom);
         @(posedge clk); #1; lat++;
      end
      req_valid = 1'b0;
      if (lat >= 64) begin
         total_cnt++;
         $display("FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
      end
   endtask

   // Full transaction with resp_ready high, checked against the model.
   task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
      logic [15:0] exp_d;
      logic        exp_e;
      int          lat;
      exp_e = (int'(addr) >= DEPTH);
      exp_d = 16'h0000;
      if (!exp_e) begin
         if (wr) model[addr] = wd;
         else    exp_d = model[addr];
      end
      resp_ready = 1'b1;
      send(wr, addr, wd);
      wait_resp(lat);
      total_cnt++;
      if (lat !== W_MAIN + 1)
         $display("FAIL latency: got %0d required %0d", lat, W_MAIN + 1);
      else pass_cnt++;
      total_cnt++;
      if (resp_rdata !== exp_d || resp_err !== exp_e || req_ready !== 1'b0)
         $display("FAIL resp_%s_%h: rdata=%h err=%b rdy=%b required rdata=%h err=%b rdy=0",
                  wr ? "wr" : "rd", addr, resp_rdata, resp_err, req_ready, exp_d, exp_e);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 16'h0000 || resp_err !== 1'b0)
         $display("FAIL release: valid=%b rdy=%b rdata=%h err=%b required 0 1 0000 0",
                  resp_valid, req_ready, resp_rdata, resp_err);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      int lat;
      rst_n = 1'b0; clear_model();
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 16'h0000)
         $display("FAIL reset_state: rdy=%b valid=%b err=%b rdata=%h required 1 0 0 0000",
                  req_ready, resp_valid, resp_err, resp_rdata);
      else pass_cnt++;
      rst_n = 1'b1;
      do_req(1'b1, 16'h0003, 16'hABCD);
      // park a read response in RESP, then reset mid-cycle
      resp_ready = 1'b0;
      send(1'b0, 16'h0003, 16'h0000);
      wait_resp(lat);
      total_cnt++;
      if (resp_rdata !== 16'hABCD) $display("FAIL pre_reset_read: got %h required abcd", resp_rdata);
      else pass_cnt++;
      #3 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 16'h0000)
         $display("FAIL async_reset: rdy=%b valid=%b err=%b rdata=%h required 1 0 0 0000",
                  req_ready, resp_valid, resp_err, resp_rdata);
      else pass_cnt++;
      clear_model();
      #1 rst_n = 1'b1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (resp_valid !== 1'b0) $display("FAIL resp_dropped: valid=%b required 0", resp_valid);
      else pass_cnt++;
      do_req(1'b0, 16'h0003, 16'h0000);
   endtask

   task automatic test_write_read();
      do_req(1'b1, 16'h0005, 16'hBEEF);
      do_req(1'b0, 16'h0005, 16'h0000);
   endtask

   task automatic test_out_of_range();
      do_req(1'b0, 16'h0100, 16'h0000);
      do_req(1'b1, 16'h0100, 16'h1234);
      do_req(1'b0, 16'h0000, 16'h0000);
      do_req(1'b0, 16'hFFFF, 16'h0000);
   endtask

   task automatic test_random();
      logic [15:0] a;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(DEPTH, 65535));
         else                           a = 16'($urandom_range(0, 15));
         do_req(1'($urandom_range(0, 1)), a, 16'($urandom));
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [15:0] exp_d;
      exp_d = model[5];
      resp_ready = 1'b0;
      send(1'b0, 16'h0005, 16'h0000);
      wait_resp(lat);
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         total_cnt++;
         if (resp_valid !== 1'b1 || resp_rdata !== exp_d || resp_err !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL backpressure_%0d: valid=%b rdata=%h err=%b rdy=%b required 1 %h 0 0",
                     i, resp_valid, resp_rdata, resp_err, req_ready, exp_d);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL bp_release: valid=%b rdy=%b required 0 1", resp_valid, req_ready);
      else pass_cnt++;
   endtask

   task automatic test_reset_busy();
      resp_ready = 1'b1;
      send(1'b1, 16'h0007, 16'h5A5A);
      req_valid = 1'b0;
      rst_n = 1'b0;
      clear_model();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1;
      total_cnt++;
      if (resp_valid !== 1'b0) $display("FAIL busy_reset_resp: valid=%b required 0", resp_valid);
      else pass_cnt++;
      do_req(1'b0, 16'h0007, 16'h0000);
   endtask

   task automatic test_back_to_back();
      int q0[$];
      int q15[$];
      int rel;
      logic p0, p15;
      rst_n = 1'b0; clear_model();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0001; resp_ready = 1'b1;
      #2 rst_n = 1'b1;
      rel = cyc;
      p0 = r0_ready; p15 = r15_ready;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (p0)  q0.push_back(cyc);
         if (p15) q15.push_back(cyc);
         p0 = r0_ready; p15 = r15_ready;
      end
      req_valid = 1'b0;
      total_cnt++;
      if (q0.size() < 6 || q15.size() < 5)
         $display("FAIL b2b_count: w0=%0d w15=%0d required >=6 >=5", q0.size(), q15.size());
      else pass_cnt++;
      if (q0.size() >= 1 && q15.size() >= 1) begin
         total_cnt++;
         if (q0[0] !== rel + 1 || q15[0] !== rel + 1)
            $display("FAIL first_accept: w0=%0d w15=%0d required %0d", q0[0], q15[0], rel + 1);
         else pass_cnt++;
      end
      for (int i = 1; i < q0.size() && i < 6; i++) begin
         total_cnt++;
         if (q0[i] - q0[i-1] !== 3)
            $display("FAIL b2b_w0_%0d: spacing %0d required 3", i, q0[i] - q0[i-1]);
         else pass_cnt++;
      end
      for (int i = 1; i < q15.size(); i++) begin
         total_cnt++;
         if (q15[i] - q15[i-1] !== 18)
            $display("FAIL b2b_w15_%0d: spacing %0d required 18", i, q15[i] - q15[i-1]);
         else pass_cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = 16'h0000; req_wdata = 16'h0000; resp_ready = 1'b1;
      test_reset();
      test_write_read();
      test_out_of_range();
      test_backpressure();
      test_random();
      test_reset_busy();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 16-bit words in the array.
REQ-002 Parameter WAIT_CYCLES, default 2, access wait states (legal range 0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  processor presents a request.
REQ-006 req_write  input  1  1 = write, 0 = read; sampled with req_valid.
REQ-007 req_addr  input  16  word address.
REQ-008 req_wdata  input  16  write data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  processor consumes response.
REQ-012 resp_rdata  output  16  read data; 0x0000 for writes and errors.
REQ-013 resp_err  output  1  address out of range.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-015 In IDLE, req_ready SHALL be 1; in BUSY and RESP, req_ready SHALL be 0.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1: latch write/addr/wdata, load the wait counter with WAIT_CYCLES, go to BUSY.
REQ-017 In BUSY, the wait counter SHALL decrement once per cycle. When it reaches 0, the access SHALL be performed and the FSM SHALL enter RESP on the same edge.
REQ-018 Latency: an acceptance edge at cycle N SHALL give resp_valid=1 from cycle N+WAIT_CYCLES+1.
REQ-019 WAIT_CYCLES=0 SHALL give BUSY a one-cycle duration.
REQ-020 An address SHALL be in range when req_addr < DEPTH.
REQ-021 Out-of-range request: no array write, resp_err=1, resp_rdata=0x0000.
REQ-022 In-range read: resp_rdata SHALL equal the array word at the latched address, sampled at the access edge; resp_err=0.
REQ-023 In-range write: the array word SHALL be updated at the access edge; resp_rdata=0x0000; resp_err=0.
REQ-024 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until a rising edge with resp_ready=1. On that edge the FSM SHALL return to IDLE, and resp_valid SHALL drop the next cycle.
REQ-025 No request overlap: a req_valid held across RESP SHALL be accepted no earlier than the first IDLE cycle.
REQ-026 Inputs req_* SHALL be ignored outside IDLE; changes during BUSY SHALL not alter the latched request.
REQ-027 A read of the address written by the immediately preceding request SHALL return the new data.
REQ-028 Outside RESP, resp_rdata and resp_err SHALL be 0.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0x0000, resp_err=0, and req_ready=1.
REQ-030 rst_n=0 SHALL clear every array word to 0x0000.
REQ-031 A write in BUSY when reset asserts SHALL be discarded; a pending response in RESP SHALL be dropped.
REQ-032 The first request SHALL be accepted on the first rising edge after rst_n deasserts with req_valid=1.

Verification
REQ-033 Reset check: pulse rst_n low mid-cycle -> outputs reach REQ-029 values without waiting for a clock edge; then read addr 0x0003 -> resp_rdata=0x0000, resp_err=0.
REQ-034 Write then read (WAIT_CYCLES=2): write 0xBEEF to 0x0005 accepted at cycle 0 -> resp_valid at cycle 3, resp_err=0, resp_rdata=0x0000; read 0x0005 -> resp_rdata=0xBEEF.
REQ-035 Out-of-range read of 0x0100 (DEPTH=256) -> resp_err=1, resp_rdata=0x0000; a following write of 0x1234 to 0x0100 -> resp_err=1, and read 0x0000 still returns 0x0000.
REQ-036 Backpressure: hold resp_ready=0 for 4 cycles in RESP -> resp_valid=1, data stable, and req_ready=0 throughout; raise resp_ready -> IDLE next cycle.
REQ-037 Reset mid-operation: write 0x5A5A to 0x0007, assert rst_n low in BUSY -> after release, read 0x0007 returns 0x0000.
REQ-038 Back-to-back: req_valid held high with resp_ready=1 -> consecutive acceptances exactly WAIT_CYCLES+3 cycles apart; sweep WAIT_CYCLES=0 and 15.
